// File: rtl/regfile_dump_reader.sv
// Register-file dump engine: walks a wrapping index range and streams {index,data} beats.
// Optional running checksum of sent words is built when REGDUMP_CHECKSUM_EN is defined.
module regfile_dump_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] ctrl_readReg,
  input  logic [DATA_W-1:0] data_readReg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_reg,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_last_reg;
  logic [DATA_W-1:0]   r_out_data;
  logic [ADDR_W-1:0]   r_out_reg;
  logic                r_out_last;
  logic                r_out_valid;
  logic                w_hs;
  logic                w_go;

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) r_state <= IDLE;
    else               r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_hs   = r_out_valid && out_ready;
    w_go   = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_go = start;
        if (start) w_next = ISSUE;
      end
      ISSUE: w_next = SEND;
      SEND: begin
        if (w_hs) w_next = r_out_last ? DONE : ISSUE;
      end
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Address only moves when leaving IDLE or after a non-final handshake,
  // so the read mux always settles for a full cycle before capture.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_addr      <= '0;
      r_last_reg  <= '0;
      r_out_data  <= '0;
      r_out_reg   <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_go) begin
        r_addr     <= first_reg;
        r_last_reg <= last_reg;
      end
      if (r_state == ISSUE) begin
        r_out_data  <= data_readReg;
        r_out_reg   <= r_addr;
        r_out_last  <= (r_addr == r_last_reg);
        r_out_valid <= 1'b1;
      end
      if (r_state == SEND && w_hs) begin
        r_out_valid <= 1'b0;
        if (!r_out_last) r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end

`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n)                r_checksum <= '0;
    else if (w_go)                    r_checksum <= '0;
    else if (r_state == SEND && w_hs) r_checksum <= r_checksum + r_out_data;
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign ctrl_readReg = r_addr;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_reg      = r_out_reg;
  assign out_last     = r_out_last;
  assign busy         = (r_state != IDLE);
  assign done         = (r_state == DONE);

endmodule
